// File: rtl/ssd_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds arbiter states, source indices, blank codes and priority pick.
package ssd_display_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_e;

    localparam int unsigned SRC_KEYPAD = 0;
    localparam int unsigned SRC_MSG    = 1;
    localparam int unsigned SRC_ALARM  = 2;

    localparam logic [4:0]  BLANK_DIGIT = 5'h1F;
    localparam logic [19:0] BLANK_FRAME = {4{BLANK_DIGIT}};

    // Fixed priority: alarm over message over keypad, one-hot result.
    function automatic logic [2:0] pick_winner(input logic [2:0] req);
        logic [2:0] w;
        w = 3'b000;
        if (req[SRC_ALARM])
            w[SRC_ALARM] = 1'b1;
        else if (req[SRC_MSG])
            w[SRC_MSG] = 1'b1;
        else if (req[SRC_KEYPAD])
            w[SRC_KEYPAD] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/ssd_display_arbiter_scan.sv
// Digit-scan prescaler: periodic scan tick and a 2-bit digit index.
// Runs free of the arbitration state; only reset touches it.
module scan_prescaler
    import ssd_display_arbiter_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       scan_tick_o,
    output logic [1:0] digit_sel_o
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic          tick;

    assign tick        = (cnt_q == LAST);
    assign scan_tick_o = tick;
    assign digit_sel_o = dig_q;

    // Wrap the prescaler at its last count; step the digit on that wrap.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + PW'(1);
        dig_d = tick ? dig_q + 2'd1 : dig_q;
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Fixed-priority owner arbitration for a shared seven-segment display.
// Owner keeps the display for a minimum dwell; alarm may preempt.
module ssd_display_arbiter
    import ssd_display_arbiter_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned REFRESH_DIV  = 100_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  req_i,
    input  logic [19:0] data0_i,
    input  logic [19:0] data1_i,
    input  logic [19:0] data2_i,
    output logic [2:0]  grant_o,
    output logic [19:0] frame_out_o,
    output logic        scan_tick_o,
    output logic [1:0]  digit_sel_o
);

    localparam int unsigned DW =
        (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    arb_state_e    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [19:0]   frame_q, frame_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]    winner;
    logic          settle;

    assign grant_o     = grant_q;
    assign frame_out_o = frame_q;

    // Next owner: IDLE and an expiring dwell both re-run the priority pick,
    // so the hand-over lands right after the last dwell cycle.
    always_comb begin
        winner  = pick_winner(req_i);
        state_d = state_q;
        grant_d = grant_q;
        dwell_d = dwell_q;
        settle  = 1'b0;
        case (state_q)
            ST_IDLE: settle = 1'b1;
            ST_HOLD: begin
                if (req_i[SRC_ALARM] && !grant_q[SRC_ALARM]) begin
                    grant_d = 3'b100;
                    dwell_d = DWELL_LOAD;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - DW'(1);
                end else begin
                    settle = 1'b1;
                end
            end
            ST_OPEN: settle = 1'b1;
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        if (settle) begin
            if (winner == 3'b000) begin
                state_d = ST_IDLE;
                grant_d = '0;
            end else if (winner != grant_q) begin
                state_d = ST_HOLD;
                grant_d = winner;
                dwell_d = DWELL_LOAD;
            end else begin
                state_d = ST_OPEN;
            end
        end
    end

    // Frame follows the next owner so grant and data move together.
    always_comb begin
        frame_d = BLANK_FRAME;
        case (1'b1)
            grant_d[SRC_ALARM]:  frame_d = data2_i;
            grant_d[SRC_MSG]:    frame_d = data1_i;
            grant_d[SRC_KEYPAD]: frame_d = data0_i;
            default:             frame_d = BLANK_FRAME;
        endcase
    end

    // Arbitration registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            frame_q <= BLANK_FRAME;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            frame_q <= frame_d;
            dwell_q <= dwell_d;
        end
    end

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scan_tick_o (scan_tick_o),
        .digit_sel_o (digit_sel_o)
    );

endmodule

// File: doc/ssd_display_arbiter.md
SSD_DISPLAY_ARBITER -- requirements
Module: ssd_display_arbiter

Interface
REQ-001 Parameter DWELL_CYCLES, default 50_000_000: minimum cycles a granted source owns the display.
REQ-002 Parameter REFRESH_DIV, default 100_000: clk cycles per digit-scan step.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  3  per-source display request, level; bit 2 alarm, bit 1 message, bit 0 keypad.
REQ-006 data0, data1, data2  in  20 each  per-source frame of four 5-bit digit codes; digit 0 is in [4:0].
REQ-007 grant  out  3  one-hot owner indication; all zero when idle.
REQ-008 frame_out  out  20  frame presented to the seven-segment driver.
REQ-009 scan_tick  out  1  one-cycle pulse every REFRESH_DIV cycles.
REQ-010 digit_sel  out  2  active digit index; the driver advances only on scan_tick.

Function
REQ-011 The arbiter SHALL use three states:
- IDLE: no owner.
- HOLD: owner active, dwell counter running.
- OPEN: owner active, dwell expired.
REQ-012 Priority SHALL be fixed: req[2] > req[1] > req[0]; on simultaneous requests the highest index wins.
REQ-013 In IDLE, any asserted req SHALL move the block to HOLD with grant one-hot on the winner, one cycle after the req is sampled.
REQ-014 On every grant change the dwell counter SHALL load DWELL_CYCLES-1; HOLD SHALL last exactly DWELL_CYCLES cycles, starting with the first grant cycle.
REQ-015 In HOLD, grant SHALL stay with the owner even if the owner deasserts req.
REQ-016 Exception to REQ-015: a req[2] assertion while the owner is source 0 or 1 SHALL preempt on the next cycle and restart HOLD.
REQ-017 In OPEN, each cycle the highest-priority asserted req SHALL be evaluated; if it differs from the owner, grant SHALL switch on the next cycle and re-enter HOLD.
REQ-018 In OPEN with no req asserted, the block SHALL return to IDLE on the next cycle; grant becomes 0 and frame_out becomes BLANK_FRAME.
REQ-019 In OPEN, if the owner keeps req asserted and no higher-priority req is asserted, the owner SHALL retain the display indefinitely.
REQ-020 frame_out SHALL be registered from the owner's data input every cycle (one-cycle latency) and SHALL equal BLANK_FRAME in IDLE.
REQ-021 frame_out and grant SHALL change on the same clock edge; a grant bit SHALL never be high while frame_out carries another source's data.
REQ-022 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-023 scan_tick SHALL be high for exactly the one cycle in which the prescaler holds REFRESH_DIV-1.
REQ-024 digit_sel SHALL increment modulo 4 on the cycle after each scan_tick.
REQ-025 The prescaler and digit_sel SHALL run independently of the arbitration state.
REQ-026 The dwell counter SHALL be sized to hold DWELL_CYCLES-1.
REQ-027 With DWELL_CYCLES=1, HOLD SHALL last one cycle.
REQ-028 REFRESH_DIV SHALL be at least 2.

Reset
REQ-029 While rst is high, the block SHALL hold:
- state IDLE, grant 0, frame_out BLANK_FRAME;
- scan_tick 0, digit_sel 0;
- prescaler and dwell counter 0.
REQ-030 rst asserted mid-HOLD or mid-OPEN SHALL abandon ownership with no residual grant after release.
REQ-031 The first scan_tick after rst falls SHALL occur REFRESH_DIV cycles after release.

Structure
REQ-032 A shared package SHALL hold:
- the state enumeration;
- source index constants SRC_KEYPAD=0, SRC_MSG=1, SRC_ALARM=2;
- BLANK_DIGIT=5'h1F and BLANK_FRAME=20'hFFFFF.
REQ-033 The prescaler/digit counter SHALL be a sub-module named scan_prescaler; arbitration and the dwell counter SHALL remain in ssd_display_arbiter.

Verification (DWELL_CYCLES=4, REFRESH_DIV=3)
REQ-034 Reset: hold rst for 3 cycles, then release -> grant=000, frame_out=20'hFFFFF; the first scan_tick comes 3 cycles after release and digit_sel then steps 0,1,2,3,0.
REQ-035 Simultaneous requests: req=011 from IDLE with data1=20'h12345 -> next cycle grant=010 and frame_out=20'h12345.
REQ-036 Dwell hold: source 1 drops req one cycle after its grant while req[0] is high -> grant stays 010 for 4 cycles total, then switches to 001.
REQ-037 Alarm preemption: req[2] rises during HOLD of source 0 -> grant=100 on the next cycle and frame_out=data2 on the same edge.
REQ-038 Release to idle: in OPEN, all req drop -> next cycle grant=000 and frame_out=20'hFFFFF.
REQ-039 Reset mid-operation: rst asserted during OPEN while req[1] stays high -> grant=000 during reset; grant=010 re-acquired one cycle after rst falls.
